// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution-layer phase sequencer.
package conv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_I2C_RST  = 3'd1,
    ST_I2C_RUN  = 3'd2,
    ST_MM_START = 3'd3,
    ST_MM_RUN   = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } sched_state_e;

endpackage

// File: rtl/conv_phase_wdog.sv
// Per-phase watchdog: saturating run-cycle counter that flags when TIMEOUT-1 is
// reached without done. TIMEOUT=0 disables the flag entirely.
module conv_phase_wdog #(
  parameter int unsigned TIMEOUT   = 65536,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic done,
  output logic timeout
);

  localparam logic [CNT_WIDTH-1:0] LIMIT =
    (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    timeout = 1'b0;
    if ((TIMEOUT != 0) && en && !done && (cnt_q >= LIMIT)) begin
      timeout = 1'b1;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Convolution-layer phase sequencer: runs im2col then GEMM, muxes the shared
// memory port, and watchdogs each run phase. CONV_SCHED_PERF_EN builds perf counters.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = 65536,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            phase,
  output logic                  i2c_rst_n,
  input  logic                  i2c_done,
  input  logic [ADDR_WIDTH-1:0] i2c_addr_rd,
  input  logic [ADDR_WIDTH-1:0] i2c_addr_wr,
  input  logic [DATA_WIDTH-1:0] i2c_data_wr,
  input  logic                  i2c_wr_en,
  output logic                  mm_start,
  input  logic                  mm_done,
  input  logic [ADDR_WIDTH-1:0] mm_addr_rd,
  input  logic [ADDR_WIDTH-1:0] mm_addr_wr,
  input  logic [DATA_WIDTH-1:0] mm_data_wr,
  input  logic                  mm_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr_wr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_data_rd,
  output logic [DATA_WIDTH-1:0] eng_data_rd,
  output logic [CNT_WIDTH-1:0]  perf_i2c_cycles,
  output logic [CNT_WIDTH-1:0]  perf_mm_cycles
);

  sched_state_e state_q, state_d;
  logic         start_acc;
  logic         run_phase;
  logic         phase_done;
  logic         wdog_timeout;

  assign run_phase  = (state_q == ST_I2C_RUN) || (state_q == ST_MM_RUN);
  assign phase_done = (state_q == ST_I2C_RUN) ? i2c_done :
                      (state_q == ST_MM_RUN)  ? mm_done  : 1'b0;

  // Counter is held clear outside the run states, so every run phase starts at zero.
  conv_phase_wdog #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!run_phase),
    .en      (run_phase),
    .done    (phase_done),
    .timeout (wdog_timeout)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_I2C_RST;
        end
      end
      ST_I2C_RST:  state_d = ST_I2C_RUN;
      ST_I2C_RUN: begin
        if (i2c_done) begin
          state_d = ST_MM_START;
        end else if (wdog_timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_MM_START: state_d = ST_MM_RUN;
      ST_MM_RUN: begin
        if (mm_done) begin
          state_d = ST_DONE;
        end else if (wdog_timeout) begin
          state_d = ST_ERR;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All status outputs decode the registered state, so reset forces them directly.
  always_comb begin
    busy      = (state_q == ST_I2C_RST) || (state_q == ST_I2C_RUN) ||
                (state_q == ST_MM_START) || (state_q == ST_MM_RUN);
    done      = (state_q == ST_DONE);
    error     = (state_q == ST_ERR);
    phase     = state_q;
    i2c_rst_n = (state_q == ST_I2C_RUN);
    mm_start  = (state_q == ST_MM_START);
  end

  always_comb begin
    mem_addr_rd = '0;
    mem_addr_wr = '0;
    mem_data_wr = '0;
    mem_wr_en   = 1'b0;
    if (state_q == ST_I2C_RUN) begin
      mem_addr_rd = i2c_addr_rd;
      mem_addr_wr = i2c_addr_wr;
      mem_data_wr = i2c_data_wr;
      mem_wr_en   = i2c_wr_en;
    end else if (state_q == ST_MM_RUN) begin
      mem_addr_rd = mm_addr_rd;
      mem_addr_wr = mm_addr_wr;
      mem_data_wr = mm_data_wr;
      mem_wr_en   = mm_wr_en;
    end
  end

  assign eng_data_rd = mem_data_rd;

`ifdef CONV_SCHED_PERF_EN
  logic [CNT_WIDTH-1:0] perf_i2c_q, perf_i2c_d;
  logic [CNT_WIDTH-1:0] perf_mm_q, perf_mm_d;

  always_comb begin
    perf_i2c_d = perf_i2c_q;
    perf_mm_d  = perf_mm_q;
    if (start_acc) begin
      perf_i2c_d = '0;
      perf_mm_d  = '0;
    end else begin
      if ((state_q == ST_I2C_RUN) && (perf_i2c_q != '1)) begin
        perf_i2c_d = perf_i2c_q + CNT_WIDTH'(1);
      end
      if ((state_q == ST_MM_RUN) && (perf_mm_q != '1)) begin
        perf_mm_d = perf_mm_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i2c_q <= '0;
      perf_mm_q  <= '0;
    end else begin
      perf_i2c_q <= perf_i2c_d;
      perf_mm_q  <= perf_mm_d;
    end
  end

  assign perf_i2c_cycles = perf_i2c_q;
  assign perf_mm_cycles  = perf_mm_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign perf_i2c_cycles  = '0;
  assign perf_mm_cycles   = '0;
`endif

endmodule
